// File: rtl/csr_mult_seq.sv
// Sequencer for the CSR1 (negacyclic shifter) -> CSR2 (rotator) coefficient datapath.
// Drives the shift-register enables and tags each valid CSR2 coefficient with row/column.
module csr_mult_seq #(
   parameter int N = 4,
   localparam int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          hold,
   output logic          busy,
   output logic          done,
   output logic          csr1_load,
   output logic          csr1_en,
   output logic          csr2_load,
   output logic          csr2_en,
   output logic          coeff_valid,
   output logic [CW-1:0] row_idx,
   output logic [CW-1:0] col_idx,
   output logic          last
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ROW_START,
      ST_ROW_SHIFT,
      ST_FLUSH,
      ST_DONE
   } state_t;

   localparam logic [CW-1:0] LP_LAST      = CW'(N - 1);
   localparam logic [CW-1:0] LP_SHIFT_END = CW'(N - 2);
   localparam logic [CW-1:0] LP_ONE       = CW'(1);

   state_t        r_state;
   logic [CW-1:0] r_r;
   logic [CW-1:0] r_s;
   logic [CW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [CW-1:0] r_vrow;
   logic [CW-1:0] r_vcol;
   logic          r_busy;
   logic          r_done;
   logic          r_csr1_load;
   logic          r_csr1_en;
   logic          r_csr2_load;
   logic          r_csr2_en;
   logic          r_valid;
   logic          r_last;

   logic          w_stall;
   logic          w_valid;

   assign w_stall = hold & r_busy;
   assign w_valid = r_valid & ~w_stall;

   // Output registers carry the decode of the state being entered, so each
   // branch sets the flags for its successor state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_r         <= '0;
         r_s         <= '0;
         r_row       <= '0;
         r_col       <= '0;
         r_vrow      <= '0;
         r_vcol      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_csr1_load <= 1'b0;
         r_csr1_en   <= 1'b0;
         r_csr2_load <= 1'b0;
         r_csr2_en   <= 1'b0;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
      end else begin
         // Remember the last tag actually presented; shown while not valid.
         if (w_valid) begin
            r_vrow <= r_row;
            r_vcol <= r_col;
         end
         if (!w_stall) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_csr1_load <= 1'b0;
            r_csr1_en   <= 1'b0;
            r_csr2_load <= 1'b0;
            r_csr2_en   <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_state     <= ST_LOAD;
                     r_busy      <= 1'b1;
                     r_csr1_load <= 1'b1;
                  end
               end
               ST_LOAD: begin
                  r_r         <= '0;
                  r_state     <= ST_ROW_START;
                  r_busy      <= 1'b1;
                  r_csr2_load <= 1'b1;
                  r_csr1_en   <= 1'b1;
               end
               ST_ROW_START: begin
                  r_s       <= '0;
                  r_state   <= ST_ROW_SHIFT;
                  r_busy    <= 1'b1;
                  r_csr2_en <= 1'b1;
                  r_valid   <= 1'b1;
                  r_row     <= r_r;
                  r_col     <= '0;
               end
               ST_ROW_SHIFT: begin
                  r_busy  <= 1'b1;
                  r_valid <= 1'b1;
                  if (r_s == LP_SHIFT_END) begin
                     if (r_r < LP_LAST) begin
                        r_r         <= r_r + LP_ONE;
                        r_state     <= ST_ROW_START;
                        r_csr2_load <= 1'b1;
                        r_csr1_en   <= 1'b1;
                        r_row       <= r_r;
                        r_col       <= LP_LAST;
                     end else begin
                        r_state <= ST_FLUSH;
                        r_last  <= 1'b1;
                        r_row   <= LP_LAST;
                        r_col   <= LP_LAST;
                     end
                  end else begin
                     r_s       <= r_s + LP_ONE;
                     r_csr2_en <= 1'b1;
                     r_row     <= r_r;
                     r_col     <= r_s + LP_ONE;
                  end
               end
               ST_FLUSH: begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
               ST_DONE: begin
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign csr1_load   = r_csr1_load & ~w_stall;
   assign csr1_en     = r_csr1_en & ~w_stall;
   assign csr2_load   = r_csr2_load & ~w_stall;
   assign csr2_en     = r_csr2_en & ~w_stall;
   assign coeff_valid = w_valid;
   assign last        = r_last & ~w_stall;
   assign row_idx     = w_valid ? r_row : r_vrow;
   assign col_idx     = w_valid ? r_col : r_vcol;

endmodule

// File: tb/tb_csr_mult_seq.sv
// Bench for csr_mult_seq: N=4 and N=2 instances share stimulus; each is checked every
// cycle against a step-schedule model derived from the run structure.
module tb_csr_mult_seq;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       c1l;
      logic       c1e;
      logic       c2l;
      logic       c2e;
      logic       valid;
      logic       last;
      logic [7:0] row;
      logic [7:0] col;
   } obs_t;

   logic clk;
   logic rst_n;
   logic start;
   logic hold;

   logic       busy4, done4, c1l4, c1e4, c2l4, c2e4, valid4, last4;
   logic [1:0] row4, col4;
   logic       busy2, done2, c1l2, c1e2, c2l2, c2e2, valid2, last2;
   logic [0:0] row2, col2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int nn[2]   = '{4, 2};
   int mk[2]   = '{-1, -1};
   int mrow[2] = '{0, 0};
   int mcol[2] = '{0, 0};
   int vcnt[2] = '{0, 0};
   int dcyc[2] = '{-1, -1};

   csr_mult_seq #(.N(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
      .busy(busy4), .done(done4), .csr1_load(c1l4), .csr1_en(c1e4),
      .csr2_load(c2l4), .csr2_en(c2e4), .coeff_valid(valid4),
      .row_idx(row4), .col_idx(col4), .last(last4)
   );

   csr_mult_seq #(.N(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
      .busy(busy2), .done(done2), .csr1_load(c1l2), .csr1_en(c1e2),
      .csr2_load(c2l2), .csr2_en(c2e2), .coeff_valid(valid2),
      .row_idx(row2), .col_idx(col2), .last(last2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Step k of a run: 0 = load, then N rows of N steps (row start + N-1 shifts), flush, done.
   function automatic obs_t step_of(int n, int k);
      obs_t o;
      int j, r, p;
      o = '0;
      if (k == 0) begin
         o.busy = 1'b1;
         o.c1l  = 1'b1;
      end else if (k <= n * n) begin
         j = k - 1;
         r = j / n;
         p = j % n;
         o.busy = 1'b1;
         if (p == 0) begin
            o.c2l = 1'b1;
            o.c1e = 1'b1;
            if (r > 0) begin
               o.valid = 1'b1;
               o.row   = 8'(r - 1);
               o.col   = 8'(n - 1);
            end
         end else begin
            o.c2e   = 1'b1;
            o.valid = 1'b1;
            o.row   = 8'(r);
            o.col   = 8'(p - 1);
         end
      end else if (k == n * n + 1) begin
         o.busy  = 1'b1;
         o.valid = 1'b1;
         o.last  = 1'b1;
         o.row   = 8'(n - 1);
         o.col   = 8'(n - 1);
      end else begin
         o.done = 1'b1;
      end
      return o;
   endfunction

   function automatic obs_t expect_of(int d, logic hd);
      obs_t e;
      e = (mk[d] < 0) ? obs_t'('0) : step_of(nn[d], mk[d]);
      if (e.busy && hd) begin
         e.c1l = 1'b0; e.c1e = 1'b0; e.c2l = 1'b0; e.c2e = 1'b0;
         e.valid = 1'b0; e.last = 1'b0;
      end
      if (!e.valid) begin
         e.row = 8'(mrow[d]);
         e.col = 8'(mcol[d]);
      end
      return e;
   endfunction

   function automatic obs_t get_obs(int d);
      obs_t g;
      if (d == 0) begin
         g = '{busy4, done4, c1l4, c1e4, c2l4, c2e4, valid4, last4, {6'b0, row4}, {6'b0, col4}};
      end else begin
         g = '{busy2, done2, c1l2, c1e2, c2l2, c2e2, valid2, last2, {7'b0, row2}, {7'b0, col2}};
      end
      return g;
   endfunction

   task automatic check_obs(input string tag, input int d, input obs_t got, input obs_t exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s n=%0d cyc=%0d observed=%h expected=%h (busy,done,c1l,c1e,c2l,c2e,valid,last,row,col)",
                tag, nn[d], cyc, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic advance(input int d, input logic st, input logic hd, input obs_t e);
      if (e.valid) begin
         mrow[d] = int'(e.row);
         mcol[d] = int'(e.col);
      end
      if (mk[d] < 0) begin
         if (st) mk[d] = 0;
      end else if (!(e.busy && hd)) begin
         if (e.done) mk[d] = -1;
         else        mk[d] = mk[d] + 1;
      end
   endtask

   task automatic tick(input logic st, input logic hd);
      obs_t e, g;
      @(posedge clk);
      #1 start = st;
      hold = hd;
      #1;
      for (int d = 0; d < 2; d++) begin
         e = expect_of(d, hd);
         g = get_obs(d);
         check_obs("cycle", d, g, e);
         if (g.valid) vcnt[d]++;
         if (g.done && dcyc[d] < 0) dcyc[d] = cyc;
         advance(d, st, hd, e);
      end
      cyc++;
   endtask

   task automatic new_run();
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
         vcnt[d] = 0;
         dcyc[d] = -1;
      end
   endtask

   task automatic check_reset(input string tag);
      for (int d = 0; d < 2; d++) begin
         check_obs(tag, d, get_obs(d), obs_t'('0));
         mk[d] = -1; mrow[d] = 0; mcol[d] = 0;
      end
   endtask

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      hold  = 1'b0;
      #1 rst_n = 1'b0;
      #2 check_reset("reset_state");
      #9 rst_n = 1'b1;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      // Plain run: schedule and tags checked per cycle, plus end-of-run totals.
      new_run();
      tick(1'b1, 1'b0);
      for (int i = 1; i <= 22; i++) tick(1'b0, 1'b0);
      check_int("done_cycle_n4", dcyc[0], 19);
      check_int("done_cycle_n2", dcyc[1], 7);
      check_int("valid_count_n4", vcnt[0], 16);
      check_int("valid_count_n2", vcnt[1], 4);

      // Three-cycle hold in row 1 of the N=4 run.
      new_run();
      tick(1'b1, 1'b0);
      for (int i = 1; i <= 25; i++) tick(1'b0, (i >= 8 && i <= 10));
      check_int("hold_done_cycle_n4", dcyc[0], 22);
      check_int("hold_valid_count_n4", vcnt[0], 16);
      check_int("hold_done_cycle_n2", dcyc[1], 7);

      // start held high: back-to-back runs separated by one idle cycle.
      new_run();
      for (int i = 0; i < 60; i++) tick(1'b1, 1'b0);
      check_int("repeat_first_done_n4", dcyc[0], 19);
      for (int i = 0; i < 25; i++) tick(1'b0, 1'b0);

      // Asynchronous reset in the middle of a run.
      new_run();
      tick(1'b1, 1'b0);
      for (int i = 1; i <= 9; i++) tick(1'b0, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      start = 1'b0;
      hold  = 1'b0;
      #1 check_reset("async_abort");
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check_int("abort_no_done_n4", dcyc[0], -1);
      new_run();
      tick(1'b1, 1'b0);
      for (int i = 1; i <= 22; i++) tick(1'b0, 1'b0);
      check_int("post_reset_done_n4", dcyc[0], 19);
      check_int("post_reset_valid_n4", vcnt[0], 16);

      // Random start and hold traffic.
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
